// File: rtl/isp_stack.sv
// -----------------------------------------------------------------------------
// isp_stack -- hardware return-address stack (LIFO) for CALL / RETURN.
//
// Pushes store a return address. The current top-of-stack is always presented
// to the PC mux, so a RETURN can take its target in the same cycle it pops.
// Depth, full/empty and the sticky overflow/underflow flags are all tracked here.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   push       store push_addr on top of stack
//   pop        remove top entry
//   push_addr  return address to store (MINSTW bits)
//   err_clr    synchronous clear of ovf/udf (a new error in the same cycle wins)
//   top        registered top entry, 0 when empty
//   depth      registered number of valid entries, 0..SDEPTH
//   full       depth == SDEPTH
//   empty      depth == 0
//   ovf        sticky: push attempted while full
//   udf        sticky: pop attempted while empty
//
// Optional build macro ISP_WRAP_EN: turns the storage into a circular buffer
// with a base pointer, so a push while full overwrites the oldest entry
// instead of being dropped. ovf is still raised in that case.
// -----------------------------------------------------------------------------
module isp_stack #(
   parameter int MINSTW = 8,
   parameter int SDEPTH = 8,
   localparam int PW = $clog2(SDEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [MINSTW-1:0] push_addr,
   input  logic              err_clr,
   output logic [MINSTW-1:0] top,
   output logic [PW-1:0]     depth,
   output logic              full,
   output logic              empty,
   output logic              ovf,
   output logic              udf
);

   localparam int IW = $clog2(SDEPTH);
   localparam logic [PW-1:0] DEPTH_MAX = PW'(SDEPTH);

   logic [MINSTW-1:0] mem [SDEPTH];

   logic [MINSTW-1:0] top_q, top_d;
   logic [PW-1:0]     depth_q, depth_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              we;
   logic [PW-1:0]     wr_log, rd_log;
   logic [IW-1:0]     wr_phys, rd_phys;
   logic              full_w, empty_w;

   assign full_w  = (depth_q == DEPTH_MAX);
   assign empty_w = (depth_q == '0);

   // Logical slot numbers, counted from the oldest entry.
   // A push+pop replaces the current top (slot depth-1), or slot 0 when empty.
   // A plain push (including a wrapping push while full) targets slot depth.
   assign wr_log = (push && pop) ? (empty_w ? '0 : depth_q - PW'(1)) : depth_q;
   // A pop exposes the entry below the current top.
   assign rd_log = depth_q - PW'(2);

`ifdef ISP_WRAP_EN
   logic [IW-1:0] base_q, base_d;

   // Logical slot -> physical RAM index, rotated by the base pointer.
   // Inputs never exceed 2*SDEPTH-1, so one conditional subtract suffices.
   function automatic logic [IW-1:0] to_phys(input logic [PW-1:0] lidx,
                                             input logic [IW-1:0] base);
      logic [PW:0] sum;
      sum = {1'b0, lidx} + (PW+1)'(base);
      if (sum >= (PW+1)'(SDEPTH)) begin
         sum = sum - (PW+1)'(SDEPTH);
      end
      return IW'(sum);
   endfunction

   assign wr_phys = to_phys(wr_log, base_q);
   assign rd_phys = to_phys(rd_log, base_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q <= '0;
      end else begin
         base_q <= base_d;
      end
   end
`else
   assign wr_phys = IW'(wr_log);
   assign rd_phys = IW'(rd_log);
`endif

   always_comb begin
      top_d   = top_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      we      = 1'b0;
`ifdef ISP_WRAP_EN
      base_d  = base_q;
`endif
      // Clear first so that an error raised below in the same cycle wins.
      if (err_clr) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end
      case ({push, pop})
         2'b10: begin
            if (!full_w) begin
               we      = 1'b1;
               depth_d = depth_q + PW'(1);
               top_d   = push_addr;
            end else begin
               ovf_d = 1'b1;
`ifdef ISP_WRAP_EN
               // Overwrite the oldest slot (physical index == base) and rotate.
               we     = 1'b1;
               top_d  = push_addr;
               base_d = (base_q == IW'(SDEPTH - 1)) ? '0 : base_q + IW'(1);
`endif
            end
         end
         2'b01: begin
            if (empty_w) begin
               udf_d = 1'b1;
            end else if (depth_q == PW'(1)) begin
               depth_d = '0;
               top_d   = '0;
            end else begin
               depth_d = depth_q - PW'(1);
               top_d   = mem[rd_phys];
            end
         end
         2'b11: begin
            we    = 1'b1;
            top_d = push_addr;
            if (empty_w) begin
               depth_d = PW'(1);
               udf_d   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q   <= '0;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Entry storage is deliberately not reset; top is forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem[wr_phys] <= push_addr;
      end
   end

   assign top   = top_q;
   assign depth = depth_q;
   assign full  = full_w;
   assign empty = empty_w;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

endmodule

// File: tb/tb_isp_stack.sv
// -----------------------------------------------------------------------------
// tb_isp_stack -- self-checking bench for isp_stack (SDEPTH=4, MINSTW=8).
// Directed walk through the stack scenarios followed by randomized
// push/pop/err_clr traffic, compared against a queue-based reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_isp_stack;

   localparam int TB_D  = 4;
   localparam int TB_W  = 8;
   localparam int TB_PW = $clog2(TB_D + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic [TB_W-1:0]   push_addr = '0;
   logic              err_clr = 1'b0;
   logic [TB_W-1:0]   top;
   logic [TB_PW-1:0]  depth;
   logic              full, empty, ovf, udf;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: the queue holds entries oldest-first.
   logic [TB_W-1:0] m_q[$];
   logic            m_ovf = 1'b0;
   logic            m_udf = 1'b0;

   isp_stack #(.MINSTW(TB_W), .SDEPTH(TB_D)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
      .err_clr(err_clr), .top(top), .depth(depth), .full(full), .empty(empty),
      .ovf(ovf), .udf(udf)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_apply(input logic p, input logic o, input logic [TB_W-1:0] a,
                              input logic c);
      if (c) begin
         m_ovf = 1'b0;
         m_udf = 1'b0;
      end
      if (p && !o) begin
         if (m_q.size() < TB_D) begin
            m_q.push_back(a);
         end else begin
            m_ovf = 1'b1;
`ifdef ISP_WRAP_EN
            void'(m_q.pop_front());
            m_q.push_back(a);
`endif
         end
      end else if (o && !p) begin
         if (m_q.size() == 0) m_udf = 1'b1;
         else void'(m_q.pop_back());
      end else if (p && o) begin
         if (m_q.size() == 0) begin
            m_q.push_back(a);
            m_udf = 1'b1;
         end else begin
            m_q[m_q.size()-1] = a;
         end
      end
   endtask

   task automatic check_all(input string ctx);
      logic [TB_W-1:0] exp_top;
      int sz;
      sz = m_q.size();
      exp_top = (sz == 0) ? '0 : m_q[sz-1];
      check({ctx, ".top"},   32'(top),   32'(exp_top));
      check({ctx, ".depth"}, 32'(depth), 32'(sz));
      check({ctx, ".full"},  32'(full),  32'(sz == TB_D));
      check({ctx, ".empty"}, 32'(empty), 32'(sz == 0));
      check({ctx, ".ovf"},   32'(ovf),   32'(m_ovf));
      check({ctx, ".udf"},   32'(udf),   32'(m_udf));
   endtask

   // One clocked transaction: drive on negedge, model on posedge, check 1ns later.
   task automatic step(input logic p, input logic o, input logic [TB_W-1:0] a,
                       input logic c, input string ctx);
      @(negedge clk);
      push = p; pop = o; push_addr = a; err_clr = c;
      @(posedge clk);
      model_apply(p, o, a, c);
      #1;
      $display("[TB] %s push=%0d pop=%0d addr=%02h clr=%0d -> top=%02h depth=%0d full=%0d empty=%0d ovf=%0d udf=%0d",
               ctx, p, o, a, c, top, depth, full, empty, ovf, udf);
      check_all(ctx);
      push = 1'b0; pop = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      // Reset state
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Push 3, pop 3
      step(1, 0, 8'h10, 0, "p10");
      step(1, 0, 8'h20, 0, "p20");
      step(1, 0, 8'h30, 0, "p30");
      check("plan.top30", 32'(top), 32'h30);
      check("plan.depth3", 32'(depth), 32'd3);
      step(0, 1, 8'h00, 0, "pop1");
      check("plan.top20", 32'(top), 32'h20);
      step(0, 1, 8'h00, 0, "pop2");
      step(0, 1, 8'h00, 0, "pop3");
      check("plan.empty", 32'(empty), 32'd1);

      // Fill, then push while full
      for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 0, "fill");
      check("plan.ovf", 32'(ovf), 32'd1);
`ifdef ISP_WRAP_EN
      check("plan.wrap_top", 32'(top), 32'h05);
`else
      check("plan.drop_top", 32'(top), 32'h04);
`endif
      for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0, "drain");

      // Underflow and err_clr priority
      step(0, 1, 8'h00, 0, "udf_pop");
      check("plan.udf", 32'(udf), 32'd1);
      step(0, 0, 8'h00, 1, "clr");
      step(0, 1, 8'h00, 1, "clr_pop");
      check("plan.udf_wins", 32'(udf), 32'd1);
      step(0, 0, 8'h00, 1, "clr2");

      // Replace top at depth 2
      step(1, 0, 8'hA0, 0, "pA0");
      step(1, 0, 8'hB0, 0, "pB0");
      step(1, 1, 8'hC0, 0, "rplC0");
      check("plan.rpl_top", 32'(top), 32'hC0);
      step(0, 1, 8'h00, 0, "popA0");
      check("plan.topA0", 32'(top), 32'hA0);
      step(0, 1, 8'h00, 0, "popE");

      // Push+pop on empty
      step(1, 1, 8'h55, 0, "pp_empty");
      check("plan.pp_depth", 32'(depth), 32'd1);
      step(0, 1, 8'h00, 1, "pop55");

      // Async reset mid-cycle with a push pending
      step(1, 0, 8'h11, 0, "p11");
      step(1, 0, 8'h22, 0, "p22");
      push = 1'b1; push_addr = 8'h33;
      #3 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      push = 1'b0;
      #1 rst = 1'b0;
      step(0, 1, 8'h00, 0, "post_rst_pop");
      check("plan.rst_udf", 32'(udf), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         logic p, o, c;
         r = $urandom_range(0, 99);
         p = (r < 40) || (r >= 80 && r < 90);
         o = (r >= 40 && r < 80) || (r >= 80 && r < 90);
         c = ($urandom_range(0, 9) == 0);
         step(p, o, 8'($urandom), c, "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
